// File: rtl/halfdup_link_pkg.sv
// Shared types and helpers for the half-duplex link endpoint.
// Frame length includes a parity bit when HDLINK_PARITY_EN is defined.
package halfdup_link_pkg;

    typedef enum logic [3:0] {
        StIdle,
        StTxStart,
        StTxData,
        StTxPar,
        StTxStop,
        StTurn,
        StRxStart,
        StRxData,
        StRxPar,
        StRxStop
    } hdl_state_t;

    function automatic int unsigned frame_bits(input int unsigned data_w);
`ifdef HDLINK_PARITY_EN
        return data_w + 3;
`else
        return data_w + 2;
`endif
    endfunction

endpackage

// File: rtl/halfdup_link_ctrl_sio_drv.sv
// Pad driver for the shared serial line: drives d when en is high, otherwise floats.
module sio_drv (
    input  logic en,
    input  logic d,
    inout  wire  pad
);

    assign pad = en ? d : 1'bz;

endmodule

// File: rtl/halfdup_link_ctrl.sv
// Half-duplex single-wire link endpoint: serializes TX bytes, turns the line around, and
// deserializes far-end frames. Define HDLINK_PARITY_EN to add an even-parity bit.
module halfdup_link_ctrl
    import halfdup_link_pkg::*;
#(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned BIT_CYC  = 16,
    parameter int unsigned TURN_CYC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              rx_err,
    output logic              drv_en,
    output logic              busy,
    inout  wire               sio
);

    // The clock counter also times TURN, so it must cover TURN_CYC as well.
    localparam int unsigned CNT_W = ($clog2(BIT_CYC) > $clog2(TURN_CYC)) ?
                                    $clog2(BIT_CYC) : $clog2(TURN_CYC);
    localparam int unsigned BIT_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYC - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYC / 2 - 1);
    localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYC - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);

    hdl_state_t        state_q, state_d;
    logic [CNT_W-1:0]  clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              tx_bit_q, tx_bit_d;
    logic              rx_valid_q, rx_valid_d;
    logic              rx_err_q, rx_err_d;
    logic              drv_en_q, drv_en_d;
    logic              busy_q, busy_d;
    logic              tx_ready_q, tx_ready_d;
    logic              sync1_q, sync2_q;
    logic              sio_s;
    logic              bit_end;
`ifdef HDLINK_PARITY_EN
    logic              tx_par_q, tx_par_d;
    logic              rx_par_err_q, rx_par_err_d;
`endif

    assign sio_s   = sync2_q;
    assign bit_end = (clk_cnt_q == BIT_LAST);

    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q + 1'b1;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        tx_bit_d   = tx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
`ifdef HDLINK_PARITY_EN
        tx_par_d     = tx_par_q;
        rx_par_err_d = rx_par_err_q;
`endif

        unique case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                // A far-end start bit wins over a pending TX byte.
                if (!sio_s) begin
                    state_d = StRxStart;
                end else if (tx_valid && tx_ready_q) begin
                    state_d    = StTxStart;
                    tx_shift_d = tx_data;
                    tx_bit_d   = 1'b0;
`ifdef HDLINK_PARITY_EN
                    tx_par_d   = ^tx_data;
`endif
                end
            end
            StTxStart: begin
                if (bit_end) begin
                    state_d  = StTxData;
                    tx_bit_d = tx_shift_q[0];
                end
            end
            StTxData: begin
                if (bit_end) begin
                    if (bit_cnt_q == DATA_LAST) begin
`ifdef HDLINK_PARITY_EN
                        state_d  = StTxPar;
                        tx_bit_d = tx_par_q;
`else
                        state_d  = StTxStop;
                        tx_bit_d = 1'b1;
`endif
                    end else begin
                        clk_cnt_d  = '0;
                        bit_cnt_d  = bit_cnt_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_bit_d   = tx_shift_d[0];
                    end
                end
            end
`ifdef HDLINK_PARITY_EN
            StTxPar: begin
                if (bit_end) begin
                    state_d  = StTxStop;
                    tx_bit_d = 1'b1;
                end
            end
`endif
            StTxStop: begin
                if (bit_end) state_d = StTurn;
            end
            StTurn: begin
                if (clk_cnt_q == TURN_LAST) state_d = StIdle;
            end
            StRxStart: begin
                if (clk_cnt_q == HALF_LAST) state_d = sio_s ? StIdle : StRxData;
            end
            StRxData: begin
                if (bit_end) begin
                    rx_shift_d = {sio_s, rx_shift_q[DATA_W-1:1]};
                    if (bit_cnt_q == DATA_LAST) begin
`ifdef HDLINK_PARITY_EN
                        state_d = StRxPar;
`else
                        state_d = StRxStop;
`endif
                    end else begin
                        clk_cnt_d = '0;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
`ifdef HDLINK_PARITY_EN
            StRxPar: begin
                if (bit_end) begin
                    state_d      = StRxStop;
                    rx_par_err_d = (^rx_shift_q) ^ sio_s;
                end
            end
`endif
            StRxStop: begin
                if (bit_end) begin
                    state_d    = StIdle;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_shift_q;
`ifdef HDLINK_PARITY_EN
                    rx_err_d   = ~sio_s | rx_par_err_q;
`else
                    rx_err_d   = ~sio_s;
`endif
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
        end

        // Outputs are registered from the next state so they line up with it.
        drv_en_d   = state_d inside {StTxStart, StTxData, StTxPar, StTxStop};
        busy_d     = (state_d != StIdle);
        tx_ready_d = (state_d == StIdle) && sync1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            clk_cnt_q  <= '0;
            bit_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            tx_bit_q   <= 1'b1;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            drv_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
`ifdef HDLINK_PARITY_EN
            tx_par_q     <= 1'b0;
            rx_par_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            tx_bit_q   <= tx_bit_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
            drv_en_q   <= drv_en_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
            sync1_q    <= sio;
            sync2_q    <= sync1_q;
`ifdef HDLINK_PARITY_EN
            tx_par_q     <= tx_par_d;
            rx_par_err_q <= rx_par_err_d;
`endif
        end
    end

    sio_drv u_sio_drv (
        .en  (drv_en_q),
        .d   (tx_bit_q),
        .pad (sio)
    );

    assign tx_ready = tx_ready_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;
    assign drv_en   = drv_en_q;
    assign busy     = busy_q;

endmodule
